shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle 16-bit shifter for the ALU datapath. Accepts a shift command (operation, amount, operand) on a start strobe, then shifts one bit position per clock through a row of per-bit 4:1 select cells. It drives those cells' select lines itself and signals completion with a one-cycle done pulse. It is the control end of the per-bit shifting cell interface: it produces the select codes that the cells consume.

## Interface
- WIDTH, 16, datapath width in bits
- CNT_W, 4, width of shift amount (log2 WIDTH)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right)
- amount  in  CNT_W  shift distance, 0..15
- data_in  in  WIDTH  operand
- data_out  out  WIDTH  shift register contents
- carry_out  out  1  last bit shifted or rotated out
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE.
- Per-bit cell select code:
  - 00: hold
  - 01: take bit i-1; bit 0 takes fill
  - 10: take bit i+1; MSB takes fill
  - 11: load data_in
- IDLE with start=1:
  - Cells get select 11. Register loads data_in; op and amount are latched; counter loads amount; carry_out clears to 0.
  - Next state is SHIFT if amount≠0, else DONE.
- SHIFT, each cycle:
  - SLL uses select 01 with fill 0; carry_out gets the old MSB.
  - SRL uses select 10 with fill 0; carry_out gets the old bit 0.
  - SRA uses select 10 with fill equal to the old MSB; carry_out gets the old bit 0.
  - ROR uses select 10 with fill equal to the old bit 0; carry_out gets the old bit 0.
  - Counter decrements. When the counter equals 1, next state is DONE.
- DONE: done=1 and select 00, for exactly one cycle, then IDLE.
- IDLE without start: select 00; data_out and carry_out hold their values indefinitely.
- start while busy (SHIFT or DONE): ignored, with no queuing. A new command is accepted in the cycle after DONE at the earliest.
- op and amount are latched at start. Input changes during SHIFT have no effect.
- amount=0: data_out=data_in and carry_out=0, with done still pulsed.
- Reset: state=IDLE, data_out=0, carry_out=0, busy=0, done=0. Reset asserted mid-SHIFT aborts immediately and the command is lost.

## Timing
- Start sampled at the rising edge that ends cycle t. done is high in cycle t+1+amount; busy is high in cycles t+1 .. t+1+amount.
- Latency:
  - amount=0: done in t+1.
  - amount=15: done in t+16.
- Throughput: one command per amount+2 cycles, since the earliest next start is in cycle t+2+amount.
- data_out and carry_out are valid and final while done=1. Both stay stable until the next accepted start.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package shift_pkg holds:
  - op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROR
  - select encodings: SEL_HOLD, SEL_FROM_LOW, SEL_FROM_HIGH, SEL_LOAD
  - state enum: IDLE, SHIFT, DONE
- Sub-module shift_cell: one flip-flop plus a 4:1 mux on (hold, bit i-1, bit i+1, data_in bit).
  - Instantiated WIDTH times in a generate loop.
  - Select, fill and load inputs come from the sequencer FSM.
  - Its async reset is tied to rst_n.
- FSM, counter and carry logic live in shift_sequencer.

## Test plan
- Reset: hold rst_n=0 with random inputs → data_out=0x0000, carry_out=0, busy=0, done=0.
- SLL: data_in=0x8001, amount=1 → done at t+2, data_out=0x0002, carry_out=1.
- SRA: data_in=0x8000, amount=15 → done at t+16, data_out=0xFFFF, carry_out=0. SRL with the same inputs → data_out=0x0001.
- ROR and amount=0:
  - ROR, data_in=0x1234, amount=4 → data_out=0x4123, carry_out=0.
  - Any op, data_in=0xBEEF, amount=0 → done at t+1, data_out=0xBEEF, carry_out=0.
- start, op and data_in changed during SHIFT:
  - SRL, data_in=0x00F0, amount=4 → result 0x000F; the extra start is ignored.
  - A second command issued in the cycle after done → accepted normally.
- Assert rst_n low mid-SHIFT (SLL 0x0001 by 8, reset at t+3) → all outputs 0, no done. The next command runs cleanly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: shift ops, per-bit cell select codes
// and the sequencer state.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SEL_HOLD      = 2'b00,
        SEL_FROM_LOW  = 2'b01,
        SEL_FROM_HIGH = 2'b10,
        SEL_LOAD      = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_cell.sv
// One bit of the shift register: a flip-flop fed by a 4:1 mux choosing hold,
// the lower neighbour, the upper neighbour or the load bit.
module shift_cell
    import shift_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  sel_e sel,
    input  logic from_low,
    input  logic from_high,
    input  logic load_bit,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every cell samples
    // its neighbours' pre-edge values; blocking here would ripple one shift across the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            unique case (sel)
                SEL_HOLD:      q <= q;
                SEL_FROM_LOW:  q <= from_low;
                SEL_FROM_HIGH: q <= from_high;
                SEL_LOAD:      q <= load_bit;
                default:       q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: latches a shift command on start, then steps a row of
// shift_cell bits one position per clock and pulses done when finished.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    state_e           state, state_nxt;
    sel_e             sel;
    logic             fill;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        sel       = SEL_HOLD;
        fill      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    sel       = SEL_LOAD;
                    state_nxt = (amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                unique case (op_q)
                    OP_SLL: begin sel = SEL_FROM_LOW;  fill = 1'b0;       end
                    OP_SRL: begin sel = SEL_FROM_HIGH; fill = 1'b0;       end
                    OP_SRA: begin sel = SEL_FROM_HIGH; fill = q[WIDTH-1]; end
                    OP_ROR: begin sel = SEL_FROM_HIGH; fill = q[0];       end
                    default: sel = SEL_HOLD;
                endcase
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the latched command registers are reset along with the control state
    // so no X can leak into the select or fill logic before the first start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_SLL;
            cnt       <= '0;
            carry_out <= 1'b0;
        end else if (state == IDLE && start) begin
            op_q      <= op_e'(op);
            cnt       <= amount;
            carry_out <= 1'b0;
        end else if (state == SHIFT) begin
            cnt       <= cnt - CNT_W'(1);
            carry_out <= (op_q == OP_SLL) ? q[WIDTH-1] : q[0];
        end
    end

    // The end cells take the fill bit in place of the missing neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic from_low, from_high;
        if (i == 0) begin : g_lsb
            assign from_low = fill;
        end else begin : g_low
            assign from_low = q[i-1];
        end
        if (i == WIDTH - 1) begin : g_msb
            assign from_high = fill;
        end else begin : g_high
            assign from_high = q[i+1];
        end

        shift_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .sel       (sel),
            .from_low  (from_low),
            .from_high (from_high),
            .load_bit  (data_in[i]),
            .q         (q[i])
        );
    end

    assign data_out = q;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a behavioural shift model fills a scoreboard
// at each start, and entries are popped and compared when done is seen.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        carry_out;
    logic        busy;
    logic        done;

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic        carry;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .amount    (amount),
        .data_in   (data_in),
        .data_out  (data_out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Closed-form reference: result and last bit shifted out after amt steps.
    function automatic void model(input logic [1:0] o, input int a, input logic [15:0] d,
                                  output logic [15:0] r, output logic c);
        logic        [16:0] w;
        logic signed [16:0] sw;
        case (o)
            2'b00: begin w = {1'b0, d} << a; r = w[15:0]; c = (a == 0) ? 1'b0 : w[16]; end
            2'b01: begin w = {d, 1'b0} >> a; r = w[16:1]; c = (a == 0) ? 1'b0 : w[0]; end
            2'b10: begin
                sw = {d, 1'b0};
                w  = sw >>> a;
                r  = w[16:1];
                c  = (a == 0) ? 1'b0 : w[0];
            end
            default: begin
                r = (d >> a) | (d << (16 - a));
                c = (a == 0) ? 1'b0 : d[a-1];
            end
        endcase
    endfunction

    task automatic wait_done(input bit disturb);
        exp_t e;
        int   lat  = 1;
        bit   seen = 1'b0;
        while (!seen && lat <= 40) begin
            if (disturb && lat == 2) begin
                start = 1'b1; op = 2'b00; data_in = 16'hFFFF; amount = 4'd1;
            end
            if (disturb && lat == 3) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_during_shift", busy, 1'b1);
                @(negedge clk);
                lat++;
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check({e.tag, "_done_timeout"}, done, 1'b1);
        end else begin
            check({e.tag, "_latency"}, lat, e.lat);
            check({e.tag, "_data"}, data_out, e.data);
            check({e.tag, "_carry"}, carry_out, e.carry);
            check({e.tag, "_busy_at_done"}, busy, 1'b1);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] o, input logic [3:0] a,
                           input logic [15:0] d, input bit disturb);
        exp_t e;
        e.tag = tag;
        e.lat = int'(a) + 1;
        model(o, int'(a), d, e.data, e.carry);
        sb.push_back(e);
        @(negedge clk);
        op = o; amount = a; data_in = d; start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'($urandom);
        amount  = 4'($urandom);
        data_in = 16'($urandom);
        wait_done(disturb);
    endtask

    initial begin
        logic [15:0] last_data;
        logic        last_carry;
        exp_t        e;

        // Reset with random inputs applied.
        rst_n   = 1'b0;
        start   = 1'($urandom);
        op      = 2'($urandom);
        amount  = 4'($urandom);
        data_in = 16'($urandom);
        repeat (3) @(negedge clk);
        check("reset_data", data_out, 16'h0000);
        check("reset_carry", carry_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;

        run_cmd("sll_8001_1",  2'b00, 4'd1,  16'h8001, 1'b0);
        run_cmd("sra_8000_15", 2'b10, 4'd15, 16'h8000, 1'b0);
        run_cmd("srl_8000_15", 2'b01, 4'd15, 16'h8000, 1'b0);
        run_cmd("ror_1234_4",  2'b11, 4'd4,  16'h1234, 1'b0);
        run_cmd("sll_beef_0",  2'b00, 4'd0,  16'hBEEF, 1'b0);
        run_cmd("ror_beef_0",  2'b11, 4'd0,  16'hBEEF, 1'b0);

        // Inputs and an extra start during SHIFT are ignored; next command goes
        // in the cycle right after done.
        run_cmd("srl_00f0_4_disturbed", 2'b01, 4'd4, 16'h00F0, 1'b1);
        run_cmd("sra_b0b0_3_back2back", 2'b10, 4'd3, 16'hB0B0, 1'b0);

        // Idle with random inputs: outputs hold, done pulsed only once.
        last_data  = data_out;
        last_carry = carry_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 2'($urandom); amount = 4'($urandom); data_in = 16'($urandom);
            check("idle_done", done, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_data", data_out, last_data);
            check("idle_carry", carry_out, last_carry);
        end

        // Reset in the middle of SLL 0x0001 by 8, asserted in cycle t+3.
        @(negedge clk);
        op = 2'b00; amount = 4'd8; data_in = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midreset_pre_data", data_out, 16'h0002);
        @(negedge clk);
        check("midreset_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_data", data_out, 16'h0000);
        check("midreset_carry", carry_out, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("midreset_hold_done", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("after_reset_no_done", done, 1'b0);
        end

        run_cmd("sll_a5a5_5_after_reset", 2'b00, 4'd5, 16'hA5A5, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("rand_%0d", i), 2'($urandom), 4'($urandom), 16'($urandom), 1'b0);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
